muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide unit beside the EX stage; owns the HI/LO registers.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX; runs mul/div over WIDTH+1 cycles.
//  Younger independent instructions keep flowing through the ALU meanwhile.
//  Raises stall only when a later HI/LO user (md op or MFHI/MFLO) arrives while busy.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each
//  CNT_W  6   iteration counter width, >= $clog2(WIDTH)+1
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  md_valid  in   1      ID/EX holds a valid md instruction (md_op != MD_NOP)
//  md_op     in   3      MD_* encoding (package)
//  opA       in   WIDTH  busA: dividend / multiplicand
//  opB       in   WIDTH  busB: divisor / multiplier
//  mf_req    in   1      MFHI/MFLO in ID/EX this cycle
//  flush     in   1      kill any in-flight operation
//  busy      out  1      state != IDLE
//  stall     out  1      combinational: busy & (md_valid | mf_req)
//  done      out  1      one-cycle pulse; new HI/LO valid this cycle
//  hi, lo    out  WIDTH  architectural HI/LO register values
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, hi=lo=0, done=0, counter=0; aborts any op.
//  FSM: IDLE -> RUN -> FIN -> IDLE.
//  IDLE, md_valid, op in {MULT,MULTU,DIV,DIVU}, !flush: latch |opA|,|opB| and signs.
//    Abs only for signed ops. Counter=WIDTH; -> RUN.
//  IDLE, md_valid, MTHI/MTLO, !flush: hi<=opA or lo<=opA next edge.
//    Single cycle; state stays IDLE; busy=0; done=0.
//  RUN: one radix-2 step per cycle; counter decrements; counter==1 -> FIN.
//    Multiply: shift-add into 2*WIDTH product.
//    Divide: restoring shift-subtract.
//  FIN: sign fix-up, write hi/lo, done<=1 for next cycle; -> IDLE.
//    Mult: {hi,lo}=product, negated if signA^signB.
//    Div: lo=quotient, negated if signA^signB; hi=remainder, negated if signA.
//  Timing: accept at edge ending t0; busy t1..t(WIDTH+1); hi/lo/done valid t(WIDTH+2).
//  md_valid or mf_req while busy: stall=1; instruction held by pipeline.
//    Accepted/read in the first IDLE cycle, i.e. the done cycle; no extra bubble.
//  Divide by zero: full latency, hi=opA (unmodified), lo={WIDTH{1'b1}}; no trap.
//  DIV 0x80000000/-1: lo=0x80000000, hi=0 (natural wrap; no trap).
//  flush in RUN/FIN: -> IDLE next edge; hi/lo unchanged; no done.
//    flush wins over FIN completion.
//  flush in IDLE: md_valid ignored that cycle, including MTHI/MTLO.
//  md_op=MD_NOP or undefined with md_valid: ignored; no state change.
//  done and a new accept may coincide (IDLE cycle after FIN).
// STRUCTURE
//  Shared package (muldiv_pkg): MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4,
//    MD_MTHI=5, MD_MTLO=6 opcode localparams; state encodings IDLE/RUN/FIN.
//    Same package feeds the decoder that drives md_op.
//  Sub-module muldiv_step: combinational single iteration (shift-add or shift-subtract).
//    Operates on {acc, q} regs; top keeps FSM, counter, sign flags, HI/LO.
// TESTING
//  1 MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE lo=00000001; busy t1..t33; done only t34.
//  2 MULT -3*7 -> hi=FFFFFFFF lo=FFFFFFEB; DIV -7/2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  3 DIVU 7/0 -> hi=00000007 lo=FFFFFFFF after 33 busy cycles; DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  4 mf_req at t5 -> stall=1 t5..t33, 0 at t34 with new lo visible.
//    Back-to-back MULT accepted at t34; second done at t68.
//  5 flush at t10 -> busy=0 at t11; hi/lo keep prior values; no done.
//    rst_n=0 at t20 (async, mid-clock) -> busy=0, hi=lo=0 immediately.
//  6 MTHI 00001234 in IDLE -> hi=00001234 next cycle, busy=0.
//    MTLO while busy -> stall until done cycle, then lo=opA.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that
// drives md_op: opcode encodings, FSM state encoding, and an opcode
// classification helper.
package muldiv_pkg;

   localparam logic [2:0] MD_NOP   = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } md_state_e;

   // True for the ops that take the iterative path.
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc, q} register pair.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i/q_i: current accumulator / low-word (multiplier or quotient)
//   b_i      : multiplicand or divisor magnitude
//   acc_o/q_o: next accumulator / low-word
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] sum;   // acc + (q[0] ? b : 0), carry kept
   logic [WIDTH:0] sh;    // {acc, q} shifted left one, top part
   logic           ge;    // shifted remainder >= divisor

   assign sum = {1'b0, acc_i} + (q_i[0] ? {1'b0, b_i} : '0);
   assign sh  = {acc_i, q_i[WIDTH-1]};
   assign ge  = (sh >= {1'b0, b_i});

   always_comb begin
      acc_o = acc_i;
      q_o   = q_i;
      if (is_div_i) begin
         // Remainder stays below the divisor, so it fits in WIDTH bits.
         acc_o = ge ? WIDTH'(sh - {1'b0, b_i}) : sh[WIDTH-1:0];
         q_o   = {q_i[WIDTH-2:0], ge};
      end else begin
         // Product bits drop out of acc into the top of q as q shifts right.
         acc_o = sum[WIDTH:1];
         q_o   = {sum[0], q_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   md_valid, md_op     : md instruction in ID/EX and its opcode
//   opA, opB            : dividend/multiplicand, divisor/multiplier
//   mf_req              : MFHI/MFLO in ID/EX
//   flush               : abort any in-flight operation
//   busy, stall, done   : status; stall is combinational
//   hi, lo              : architectural HI/LO
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             md_valid,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             mf_req,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               div_q, div_d;     // op is a divide
   logic               neg_q, neg_d;     // product/quotient sign: signA ^ signB
   logic               rneg_q, rneg_d;   // remainder sign: signA
   logic               dz_q, dz_d;       // divisor was zero
   logic               done_q, done_d;

   logic [WIDTH-1:0]   step_acc, step_q;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic               sgn_op, sa, sb;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (div_q),
      .acc_i    (acc_q),
      .q_i      (q_q),
      .b_i      (b_q),
      .acc_o    (step_acc),
      .q_o      (step_q)
   );

   assign prod   = {acc_q, q_q};
   assign prod_s = neg_q ? -prod : prod;

   // Only signed ops take operand magnitudes.
   assign sgn_op = (md_op == MD_MULT) || (md_op == MD_DIV);
   assign sa     = sgn_op & opA[WIDTH-1];
   assign sb     = sgn_op & opB[WIDTH-1];

   assign busy  = (state_q != IDLE);
   assign stall = busy & (md_valid | mf_req);
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (md_valid && !flush) begin
               if (md_is_arith(md_op)) begin
                  acc_d   = '0;
                  q_d     = sa ? -opA : opA;
                  b_d     = sb ? -opB : opB;
                  div_d   = (md_op == MD_DIV) || (md_op == MD_DIVU);
                  neg_d   = sa ^ sb;
                  rneg_d  = sa;
                  dz_d    = (opB == '0);
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = RUN;
               end else if (md_op == MD_MTHI) begin
                  hi_d = opA;
               end else if (md_op == MD_MTLO) begin
                  lo_d = opA;
               end
            end
         end
         RUN: begin
            acc_d = step_acc;
            q_d   = step_q;
            cnt_d = cnt_q - 1'b1;
            if (flush)             state_d = IDLE;
            else if (cnt_q == 1'b1) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (div_q) begin
                  // Divide by zero: remainder path already returns opA;
                  // the quotient is forced to all ones regardless of sign.
                  lo_d = dz_q ? '1 : (neg_q ? -q_q : q_q);
                  hi_d = rneg_q ? -acc_q : acc_q;
               end else begin
                  hi_d = prod_s[2*WIDTH-1:WIDTH];
                  lo_d = prod_s[WIDTH-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end

endmodule
